debounce_multi: RTL and testbench

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_ch.sv | 137 +++++++++++++
 rtl/debounce_multi.sv | 59 +++++
 tb/tb_debounce_multi.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared state encoding and default parameters for the multi-channel
// button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    localparam int DEF_N_CH         = 4;
    localparam int DEF_TICK_DIV     = 8192;
    localparam int DEF_STABLE_TICKS = 3;
    localparam int DEF_HOLD_TICKS   = 0;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, 4-state qualify FSM, edge
// pulses and an optional long-press hold counter.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      btn,
    input  logic      tick,
    output logic      db,
    output logic      rise,
    output logic      fall,
    output logic      long_press,
    output db_state_t state
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          s1;
    logic          s2;
    logic          db_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    db_state_t     state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ZERO;
            cnt   <= '0;
            db_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            db_q  <= db;
        end
    end

    // A level change on s aborts a pending qualification even on a tick cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ZERO: begin
                if (s2) begin
                    state_nxt = WAIT1;
                    cnt_nxt   = '0;
                end
            end
            WAIT1: begin
                if (!s2) begin
                    state_nxt = ZERO;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = ONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            ONE: begin
                if (!s2) begin
                    state_nxt = WAIT0;
                    cnt_nxt   = '0;
                end
            end
            WAIT0: begin
                if (s2) begin
                    state_nxt = ONE;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = ZERO;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = ZERO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ONE and WAIT0 share the msb, so db is a direct state decode.
    assign db   = state[1];
    assign rise = db & ~db_q;
    assign fall = ~db & db_q;

    if (HOLD_TICKS > 0) begin : g_hold
        localparam int HW = $clog2(HOLD_TICKS + 1);
        localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

        logic [HW-1:0] hold;
        logic          lp_q;

        // Saturates at HOLD_MAX so the pulse cannot re-fire within one press.
        always_ff @(posedge clk) begin
            if (reset) begin
                hold <= '0;
                lp_q <= 1'b0;
            end else begin
                lp_q <= 1'b0;
                case (state)
                    ZERO: hold <= '0;
                    ONE: begin
                        if (tick && (hold != HOLD_MAX)) begin
                            hold <= hold + HW'(1);
                            lp_q <= (hold == HOLD_MAX - HW'(1));
                        end
                    end
                    default: hold <= hold;
                endcase
            end
        end

        assign long_press = lp_q;
    end else begin : g_no_hold
        assign long_press = 1'b0;
    end

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent button debouncers sharing one sample-tick prescaler.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   btn,
    output logic [N_CH-1:0]   db,
    output logic [N_CH-1:0]   rise,
    output logic [N_CH-1:0]   fall,
    output logic [N_CH-1:0]   long_press,
    output logic              tick,
    output logic [2*N_CH-1:0] ch_state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    assign tick = (pre == '0);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        db_state_t st;

        debounce_ch #(
            .STABLE_TICKS(STABLE_TICKS),
            .HOLD_TICKS  (HOLD_TICKS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn       (btn[i]),
            .tick      (tick),
            .db        (db[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .long_press(long_press[i]),
            .state     (st)
        );

        assign ch_state[2*i +: 2] = st;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scenario bench for debounce_multi: expected pulse events are queued with
// their predicted cycle and matched against every rise/fall/long_press seen.
module tb_debounce_multi;

    localparam int N_CH = 4;
    localparam int TD   = 4;
    localparam int ST   = 3;
    localparam int HT   = 5;

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_LP   = 2;

    logic            clk;
    logic            reset;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] db;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] long_press;
    logic            tick;
    logic [2*N_CH-1:0] ch_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tick_base = 0;
    logic mon_en = 1'b0;
    logic [31:0] exp_q[$];

    debounce_multi #(
        .N_CH(N_CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .HOLD_TICKS(HT)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .db(db), .rise(rise),
        .fall(fall), .long_press(long_press), .tick(tick), .ch_state(ch_state)
    );

    // ---------------- clock / reset / cycle bookkeeping ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) tick_base <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model helpers ----------------
    function automatic logic [31:0] mk_ev(input int kind, input int ch, input int c);
        return {2'(kind), 5'(ch), 25'(c)};
    endfunction

    function automatic int next_tick(input int t);
        int r;
        r = t;
        while (((r - tick_base) % TD) != 0) r++;
        return r;
    endfunction

    // Cycle in which db changes, given the first cycle the synchronized level differs.
    function automatic int qual(input int s_cycle);
        return next_tick(s_cycle + 1) + (ST - 1) * TD + 1;
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic        pulse;
    logic [31:0] obs_ev;
    logic [31:0] exp_ev;
    logic        tick_exp;

    always @(negedge clk) begin
        if (mon_en) begin
            tick_exp = (((cyc - tick_base) % TD) == 0);
            total++;
            if (tick !== tick_exp) begin
                bad++;
                $display("FAIL tick: cycle %0d got %b expected %b", cyc, tick, tick_exp);
            end
            for (int i = 0; i < N_CH; i++) begin
                for (int k = 0; k < 3; k++) begin
                    pulse = (k == K_RISE) ? rise[i] : (k == K_FALL) ? fall[i] : long_press[i];
                    if (pulse !== 1'b0) begin
                        obs_ev = mk_ev(k, i, cyc);
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL event: unexpected kind=%0d ch=%0d cycle=%0d (queue empty)", k, i, cyc);
                        end else begin
                            exp_ev = exp_q.pop_front();
                            if (obs_ev !== exp_ev) begin
                                bad++;
                                $display("FAIL event: got kind=%0d ch=%0d cycle=%0d expected kind=%0d ch=%0d cycle=%0d",
                                         k, i, cyc, exp_ev[31:30], exp_ev[29:25], exp_ev[24:0]);
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected events still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic release_ch(input int ch);
        int q;
        step();
        btn[ch] = 1'b0;
        q = qual(cyc + 2);
        exp_q.push_back(mk_ev(K_FALL, ch, q));
        wait_drain(40);
        total++;
        if (db[ch] !== 1'b0) begin
            bad++;
            $display("FAIL release_db: ch %0d db=%b expected 0", ch, db[ch]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        btn   = '0;
        step();
        step();
        @(negedge clk);
        total++;
        if ({db, rise, fall, long_press} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", {db, rise, fall, long_press});
        end
        total++;
        if (ch_state !== '0) begin
            bad++;
            $display("FAIL reset_state: got %h expected 0", ch_state);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (tick !== 1'b1) begin
            bad++;
            $display("FAIL reset_tick_first: got %b expected 1", tick);
        end
        step();
        @(negedge clk);
        total++;
        if (tick !== 1'b0 || db !== '0) begin
            bad++;
            $display("FAIL reset_tick_second: tick=%b db=%h expected tick=0 db=0", tick, db);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_clean_press();
        int q;
        step();
        btn[0] = 1'b1;
        q = qual(cyc + 2);
        exp_q.push_back(mk_ev(K_RISE, 0, q));
        wait_until(q - 1);
        total++;
        if (db[0] !== 1'b0) begin
            bad++;
            $display("FAIL press_early: db[0]=%b one cycle before qualify, expected 0", db[0]);
        end
        wait_until(q);
        total++;
        if (db !== 4'b0001) begin
            bad++;
            $display("FAIL press_db: got %b expected 0001", db);
        end
        wait_drain(10);
        release_ch(0);
    endtask

    task automatic test_bounce();
        int   k_last;
        logic v;
        logic prev;
        prev   = 1'b0;
        k_last = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            v = ((i / 3) % 2) == 0;
            btn[1] = v;
            if (v && !prev) k_last = cyc;
            prev = v;
        end
        @(negedge clk);
        total++;
        if (db[1] !== 1'b0) begin
            bad++;
            $display("FAIL bounce_db: db[1]=%b after toggling, expected 0", db[1]);
        end
        step();
        if (!prev) begin
            btn[1] = 1'b1;
            k_last = cyc;
        end
        exp_q.push_back(mk_ev(K_RISE, 1, qual(k_last + 2)));
        wait_drain(30);
        total++;
        if (db[1] !== 1'b1) begin
            bad++;
            $display("FAIL bounce_hold: db[1]=%b expected 1", db[1]);
        end
        release_ch(1);
    endtask

    task automatic test_glitch();
        int q;
        step();
        btn[2] = 1'b1;
        q = qual(cyc + 2);
        exp_q.push_back(mk_ev(K_RISE, 2, q));
        wait_until(q);
        for (int i = 0; i < 6 + 8; i++) begin
            step();
            if (i < 5) btn[2] = 1'b0;
            else       btn[2] = 1'b1;
            @(negedge clk);
            total++;
            if (db[2] !== 1'b1) begin
                bad++;
                $display("FAIL glitch_db: step %0d db[2]=%b expected 1", i, db[2]);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL glitch_queue: %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        release_ch(2);
    endtask

    task automatic test_long_press();
        int q;
        step();
        btn[3] = 1'b1;
        q = qual(cyc + 2);
        exp_q.push_back(mk_ev(K_RISE, 3, q));
        exp_q.push_back(mk_ev(K_LP, 3, q + HT * TD));
        wait_until(q + 40);
        total++;
        if (exp_q.size() != 0 || db[3] !== 1'b1) begin
            bad++;
            $display("FAIL long_press: pending=%0d db[3]=%b expected pending=0 db=1", exp_q.size(), db[3]);
            exp_q.delete();
        end
        release_ch(3);
    endtask

    task automatic test_reset_mid();
        int q;
        int q2;
        step();
        btn = '1;
        q = qual(cyc + 2);
        for (int i = 0; i < N_CH; i++) exp_q.push_back(mk_ev(K_RISE, i, q));
        wait_until(q);
        total++;
        if (db !== 4'hF) begin
            bad++;
            $display("FAIL all_press: db=%b expected 1111", db);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        q2 = qual(cyc + 2);
        @(negedge clk);
        total++;
        if ({db, rise, fall, long_press} !== '0) begin
            bad++;
            $display("FAIL reset_mid: outputs %h expected 0", {db, rise, fall, long_press});
        end
        for (int i = 0; i < N_CH; i++) exp_q.push_back(mk_ev(K_RISE, i, q2));
        wait_until(q2);
        total++;
        if (db !== 4'hF) begin
            bad++;
            $display("FAIL requalify: db=%b expected 1111", db);
        end
        step();
        btn = '0;
        q = qual(cyc + 2);
        for (int i = 0; i < N_CH; i++) exp_q.push_back(mk_ev(K_FALL, i, q));
        wait_drain(40);
        total++;
        if (db !== 4'h0) begin
            bad++;
            $display("FAIL all_release: db=%b expected 0000", db);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_press();
        test_reset_mid();
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_queue: %0d pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
